// File: rtl/cube_mode_sequencer.sv
// rtl/cube_mode_sequencer.sv - LED-cube control FSM: countdown, position/mode select, animation/pause
// Optional idle auto-off: define CUBE_IDLE_TIMEOUT_EN
module cube_mode_sequencer #(
  parameter int N_MODES     = 4,
  parameter int MODE_W      = 2,
  parameter int CD_STEPS    = 3,
  parameter int TICK_CYCLES = 50000000,
  parameter int IDLE_CYCLES = 1500000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sensor,
  input  logic              i_load,
  input  logic              i_pause,
  input  logic [MODE_W-1:0] i_mode_sel,
  output logic              o_off,
  output logic              o_cda,
  output logic              o_pos,
  output logic              o_color,
  output logic              o_sa,
  output logic              o_ped,
  output logic [MODE_W-1:0] o_mode,
  output logic [3:0]        o_cd_remaining,
  output logic [3:0]        o_state
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_OFF        = 4'd0,
    S_CD         = 4'd1,
    S_POS_SEL    = 4'd2,
    S_POS_HOLD   = 4'd3,
    S_COL_SEL    = 4'd4,
    S_COL_HOLD   = 4'd5,
    S_ANIM       = 4'd6,
    S_PAUSED     = 4'd7,
    S_RESEL_HOLD = 4'd8
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [MODE_W-1:0]   r_mode;
  logic [MODE_W-1:0]   w_mode_nx;
  logic [3:0]          r_cd;
  logic [3:0]          w_cd_nx;
  logic [TICK_W-1:0]   r_tick;
  logic [TICK_W-1:0]   w_tick_nx;

`ifdef CUBE_IDLE_TIMEOUT_EN
  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  logic [IDLE_W-1:0]   r_idle;
  logic [IDLE_W-1:0]   w_idle_nx;
`endif

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_OFF;
      r_mode  <= '0;
      r_cd    <= 4'd0;
      r_tick  <= '0;
`ifdef CUBE_IDLE_TIMEOUT_EN
      r_idle  <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_cd    <= w_cd_nx;
      r_tick  <= w_tick_nx;
`ifdef CUBE_IDLE_TIMEOUT_EN
      r_idle  <= w_idle_nx;
`endif
    end
  end

  // Next-state, countdown timing and mode latch
  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_cd_nx    = 4'd0;
    w_tick_nx  = '0;
    case (r_state)
      S_OFF: begin
        if (i_sensor) begin
          w_state_nx = S_CD;
          w_cd_nx    = 4'(CD_STEPS);
        end
      end
      S_CD: begin
        w_cd_nx = r_cd;
        if (r_tick == TICK_W'(TICK_CYCLES - 1)) begin
          w_cd_nx = r_cd - 4'd1;
          if (r_cd == 4'd1) w_state_nx = S_POS_SEL;
        end else begin
          w_tick_nx = r_tick + 1'b1;
        end
      end
      S_POS_SEL:  if (i_load)  w_state_nx = S_POS_HOLD;
      S_POS_HOLD: if (!i_load) w_state_nx = S_COL_SEL;
      S_COL_SEL: begin
        if (i_load) begin
          w_state_nx = S_COL_HOLD;
          // out-of-range requests fall back to mode 0
          w_mode_nx  = (32'(i_mode_sel) >= N_MODES) ? '0 : i_mode_sel;
        end
      end
      S_COL_HOLD: if (!i_load) w_state_nx = S_ANIM;
      S_ANIM: begin
        if (i_pause)     w_state_nx = S_PAUSED;
        else if (i_load) w_state_nx = S_RESEL_HOLD;
      end
      S_PAUSED:     if (!i_pause) w_state_nx = S_ANIM;
      S_RESEL_HOLD: if (!i_load)  w_state_nx = S_COL_SEL;
      default:      w_state_nx = S_OFF;
    endcase

`ifdef CUBE_IDLE_TIMEOUT_EN
    // Idle timer only advances while parked in a waiting state with no key down
    w_idle_nx = '0;
    if ((r_state == S_POS_SEL || r_state == S_COL_SEL || r_state == S_PAUSED) &&
        (w_state_nx == r_state) && !i_load && !i_pause) begin
      if (r_idle == IDLE_W'(IDLE_CYCLES - 1)) begin
        w_state_nx = S_OFF;
      end else begin
        w_idle_nx = r_idle + 1'b1;
      end
    end
`endif
  end

  // Moore strobes decoded from the state register
  always_comb begin
    o_off   = (r_state == S_OFF);
    o_cda   = (r_state == S_CD);
    o_pos   = (r_state == S_POS_SEL) || (r_state == S_POS_HOLD);
    o_color = (r_state == S_COL_SEL) || (r_state == S_COL_HOLD) ||
              (r_state == S_RESEL_HOLD);
    o_sa    = (r_state == S_ANIM);
    o_ped   = (r_state == S_PAUSED);
  end

  assign o_mode         = r_mode;
  assign o_cd_remaining = r_cd;
  assign o_state        = r_state;

endmodule
